signed_frame_accumulator: RTL and testbench

//  Sequential consumer of 32-bit signed two's-complement operands. Sums each frame
//  of FRAME_LEN samples into a signed accumulator. Detects overflow with the

---
 rtl/signed_frame_accumulator_if.sv | 16 +
 rtl/signed_frame_accumulator.sv | 60 ++++++
 tb/tb_signed_frame_accumulator.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/signed_frame_accumulator_if.sv
// signed_frame_accumulator_if: operand stream in, frame result stream out, plus abort and progress count.
interface signed_frame_accumulator_if #(parameter int WIDTH = 32);
   logic             clear;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_ovf;
   logic [7:0]       count;
   modport master (output clear, in_valid, in_data, out_ready,
                   input  in_ready, out_valid, out_data, out_ovf, count);
   modport slave  (input  clear, in_valid, in_data, out_ready,
                   output in_ready, out_valid, out_data, out_ovf, count);
endinterface

// File: rtl/signed_frame_accumulator.sv
// signed_frame_accumulator: sums FRAME_LEN signed samples per frame with sign-rule overflow detection,
// saturating or wrapping, and holds each frame result on a valid/ready output.
module signed_frame_accumulator #(
   parameter int WIDTH     = 32,
   parameter int FRAME_LEN = 4,
   parameter int SAT       = 1
) (
   input logic                        clk,
   input logic                        rst_n,
   signed_frame_accumulator_if.slave  bus
);
   localparam logic [0:0] ACCUM = 1'b0;
   localparam logic [0:0] HOLD  = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d, od_q, od_d, sum, rail, acc_nx;
   logic [7:0]       cnt_q, cnt_d, cnt_nx;
   logic             ovf_q, ovf_d, oo_q, oo_d, of, take, done, last;

   always_comb begin
      take   = bus.in_valid & (state_q == ACCUM);
      done   = (state_q == HOLD) & bus.out_ready;
      sum    = acc_q + bus.in_data;
      of     = (acc_q[WIDTH-1] == bus.in_data[WIDTH-1]) & (sum[WIDTH-1] != acc_q[WIDTH-1]);
      rail   = acc_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      acc_nx = (of && SAT != 0) ? rail : sum;
      cnt_nx = cnt_q + 8'd1;
      last   = cnt_nx == 8'(FRAME_LEN);
      state_d = bus.clear ? ACCUM : (take & last) ? HOLD : done ? ACCUM : state_q;
      acc_d   = (bus.clear | done) ? '0 : take ? acc_nx : acc_q;
      cnt_d   = (bus.clear | done) ? '0 : take ? cnt_nx : cnt_q;
      ovf_d   = (bus.clear | done) ? 1'b0 : take ? (ovf_q | of) : ovf_q;
      od_d    = (!bus.clear & take & last) ? acc_nx : od_q;
      oo_d    = (!bus.clear & take & last) ? (ovf_q | of) : oo_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         od_q    <= '0;
         oo_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         od_q    <= od_d;
         oo_q    <= oo_d;
      end
   end

   assign bus.in_ready  = state_q == ACCUM;
   assign bus.out_valid = state_q == HOLD;
   assign bus.out_data  = od_q;
   assign bus.out_ovf   = oo_q;
   assign bus.count     = cnt_q;
endmodule

// File: tb/tb_signed_frame_accumulator.sv
// tb_signed_frame_accumulator: scoreboard bench for a saturating and a wrapping accumulator instance.
module tb_signed_frame_accumulator;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int failures = 0;
   logic [32:0] q1[$];
   logic [32:0] q0[$];
   logic [31:0] vals[4];

   always #5 clk = ~clk;

   signed_frame_accumulator_if b1();
   signed_frame_accumulator_if b0();
   signed_frame_accumulator #(.WIDTH(32), .FRAME_LEN(4), .SAT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   signed_frame_accumulator #(.WIDTH(32), .FRAME_LEN(4), .SAT(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));

   // Reference sum in 64-bit arithmetic, clamped or re-wrapped into 32 bits.
   function automatic logic [32:0] model(input bit sat);
      longint a = 0;
      bit o = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a = a + longint'(signed'(vals[i]));
         if (a > 64'sh7FFFFFFF || a < -64'sh80000000) begin
            o = 1'b1;
            a = sat ? ((a > 0) ? 64'sh7FFFFFFF : -64'sh80000000) : longint'(signed'(a[31:0]));
         end
      end
      return {o, a[31:0]};
   endfunction

   task automatic set_vals(input logic [31:0] a, b, c, d);
      vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = d;
   endtask

   task automatic drive_frame(input bit use0, input bit push, input string nm);
      if (push) begin
         if (use0) q0.push_back(model(1'b0)); else q1.push_back(model(1'b1));
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (use0) begin b0.in_valid = 1'b1; b0.in_data = vals[i]; end
         else begin b1.in_valid = 1'b1; b1.in_data = vals[i]; end
      end
      @(negedge clk);
      b0.in_valid = 1'b0;
      b1.in_valid = 1'b0;
      checks++;
      if ((use0 ? b0.out_valid : b1.out_valid) !== 1'b1) begin
         failures++;
         $display("FAIL %s_latency out_valid=%b required 1", nm, use0 ? b0.out_valid : b1.out_valid);
      end
   endtask

   task automatic wait_out(input string nm);
      logic [32:0] e;
      int c = 0;
      while (!b1.out_valid && c < 20) begin @(negedge clk); c++; end
      checks++;
      if (!b1.out_valid) begin
         failures++;
         $display("FAIL %s_timeout out_valid=0 required 1", nm);
      end else begin
         e = q1.pop_front();
         if ({b1.out_ovf, b1.out_data} !== e) begin
            failures++;
            $display("FAIL %s data=%h ovf=%b required data=%h ovf=%b", nm, b1.out_data, b1.out_ovf, e[31:0], e[32]);
         end
         b1.out_ready = 1'b1;
         @(negedge clk);
         b1.out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({b1.out_valid, b1.in_ready, b1.count, b1.out_data, b1.out_ovf} !== {1'b0, 1'b1, 8'd0, 32'd0, 1'b0}) begin
         failures++;
         $display("FAIL reset_state valid=%b ready=%b count=%0d data=%h ovf=%b required 0 1 0 0 0",
                  b1.out_valid, b1.in_ready, b1.count, b1.out_data, b1.out_ovf);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      set_vals(32'd10, -32'sd3, 32'd7, -32'sd20);
      drive_frame(1'b0, 1'b1, "basic");
      wait_out("basic");
   endtask

   task automatic test_saturate();
      set_vals(32'h7FFFFFF0, 32'h20, 32'd1, 32'hFFFFFFFF);
      drive_frame(1'b0, 1'b1, "sat_pos");
      wait_out("sat_pos");
      set_vals(32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0);
      drive_frame(1'b0, 1'b1, "sat_neg");
      wait_out("sat_neg");
   endtask

   task automatic test_wrap();
      logic [32:0] e;
      set_vals(32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0);
      drive_frame(1'b1, 1'b1, "wrap");
      e = q0.pop_front();
      checks++;
      if ({b0.out_ovf, b0.out_data} !== e) begin
         failures++;
         $display("FAIL wrap data=%h ovf=%b required data=%h ovf=%b", b0.out_data, b0.out_ovf, e[31:0], e[32]);
      end
      b0.out_ready = 1'b1;
      @(negedge clk);
      b0.out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [32:0] e;
      set_vals(32'd100, 32'd200, -32'sd50, 32'd3);
      drive_frame(1'b0, 1'b1, "bp");
      e = q1[0];
      b1.in_valid = 1'b1;
      b1.in_data = 32'd99;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({b1.in_ready, b1.out_valid, b1.count, b1.out_ovf, b1.out_data} !== {1'b0, 1'b1, 8'd4, e}) begin
            failures++;
            $display("FAIL bp_hold ready=%b valid=%b count=%0d data=%h required 0 1 4 %h",
                     b1.in_ready, b1.out_valid, b1.count, b1.out_data, e[31:0]);
         end
      end
      b1.in_valid = 1'b0;
      wait_out("bp_result");
      checks++;
      if ({b1.in_ready, b1.count, b1.out_data} !== {1'b1, 8'd0, e[31:0]}) begin
         failures++;
         $display("FAIL bp_exit ready=%b count=%0d data=%h required 1 0 %h", b1.in_ready, b1.count, b1.out_data, e[31:0]);
      end
      set_vals(32'd1, 32'd1, 32'd1, 32'd1);
      drive_frame(1'b0, 1'b1, "bp_next");
      wait_out("bp_next");
   endtask

   task automatic test_clear();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         b1.in_valid = 1'b1;
         b1.in_data = 32'd7;
      end
      @(negedge clk);
      checks++;
      if (b1.count !== 8'd2) begin
         failures++;
         $display("FAIL clear_pre count=%0d required 2", b1.count);
      end
      b1.clear = 1'b1;
      b1.in_data = 32'd100;
      @(negedge clk);
      b1.clear = 1'b0;
      b1.in_valid = 1'b0;
      checks++;
      if ({b1.count, b1.out_valid, b1.in_ready} !== {8'd0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL clear_post count=%0d valid=%b ready=%b required 0 0 1", b1.count, b1.out_valid, b1.in_ready);
      end
      set_vals(32'd5, 32'd5, 32'd5, 32'd5);
      drive_frame(1'b0, 1'b1, "clear_next");
      wait_out("clear_next");
   endtask

   task automatic test_async_reset();
      set_vals(32'd9, 32'd9, 32'd9, 32'd9);
      drive_frame(1'b0, 1'b0, "rst_hold");
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({b1.out_valid, b1.count, b1.out_data} !== {1'b0, 8'd0, 32'd0}) begin
         failures++;
         $display("FAIL rst_hold valid=%b count=%0d data=%h required 0 0 0", b1.out_valid, b1.count, b1.out_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         b1.in_valid = 1'b1;
         b1.in_data = 32'd3;
      end
      @(negedge clk);
      b1.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({b1.out_valid, b1.count, b1.out_data} !== {1'b0, 8'd0, 32'd0}) begin
         failures++;
         $display("FAIL rst_accum valid=%b count=%0d data=%h required 0 0 0", b1.out_valid, b1.count, b1.out_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      set_vals(-32'sd4, 32'd12, 32'd2, -32'sd1);
      drive_frame(1'b0, 1'b1, "rst_next");
      wait_out("rst_next");
   endtask

   task automatic test_back_to_back();
      for (int f = 0; f < 3; f++) begin
         set_vals($urandom, $urandom, $urandom, $urandom);
         drive_frame(1'b0, 1'b1, "b2b");
         wait_out("b2b");
      end
   endtask

   initial begin
      b1.clear = 1'b0; b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0;
      b0.clear = 1'b0; b0.in_valid = 1'b0; b0.in_data = '0; b0.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_saturate();
      test_wrap();
      test_backpressure();
      test_clear();
      test_async_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
